// File: rtl/i2s_apb_feeder.sv
// APB master that drains a small sample FIFO into an I2S transceiver TX data register and
// injects one-shot control-word writes ahead of data. Optional counters: I2S_FEEDER_STATS_EN.
module i2s_apb_feeder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [31:0] CTRL_OFS   = 32'h0,
  parameter logic [31:0] TXDATA_OFS = 32'h4,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [31:0]                 s_data,
  input  logic                        cfg_start,
  input  logic [31:0]                 cfg_word,
  output logic                        cfg_busy,
  input  logic                        tx_full,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [31:0]                 paddr,
  output logic [31:0]                 pwdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef I2S_FEEDER_STATS_EN
  ,
  output logic [15:0]                 stat_words,
  output logic [15:0]                 stat_stall
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFS;
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  logic          cfg_pend;
  logic [31:0]   cfg_word_q;
  logic          cfg_accept;
  logic          cur_cfg;
  logic          sel_cfg, sel_data;

  assign fifo_full  = (count == LW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign s_ready    = !fifo_full;
  assign fifo_level = count;
  assign push       = s_valid && !fifo_full;
  assign pop        = sel_data;

  assign cfg_accept = cfg_start && !cfg_busy;

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign pwrite  = psel;

  // Next transfer is chosen only from IDLE or on the last cycle of ACCESS.
  always_comb begin
    state_d  = state_q;
    sel_cfg  = 1'b0;
    sel_data = 1'b0;
    case (state_q)
      SETUP: state_d = ACCESS;
      IDLE, ACCESS: begin
        if (cfg_pend) begin
          state_d = SETUP;
          sel_cfg = 1'b1;
        end else if (!fifo_empty && !tx_full) begin
          state_d  = SETUP;
          sel_data = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q <= IDLE;
      cur_cfg <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      state_q <= state_d;
      if (sel_cfg) begin
        cur_cfg <= 1'b1;
        paddr   <= CTRL_ADDR;
        pwdata  <= cfg_word_q;
      end else if (sel_data) begin
        cur_cfg <= 1'b0;
        paddr   <= TXDATA_ADDR;
        pwdata  <= mem[rd_ptr];
      end
    end
  end

  // cfg_busy covers both the pending and the in-flight control write.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      cfg_pend <= 1'b0;
      cfg_busy <= 1'b0;
    end else begin
      if (cfg_accept) begin
        cfg_pend <= 1'b1;
      end else if (sel_cfg) begin
        cfg_pend <= 1'b0;
      end
      if (cfg_accept) begin
        cfg_busy <= 1'b1;
      end else if (state_q == ACCESS && cur_cfg) begin
        cfg_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (cfg_accept) begin
      cfg_word_q <= cfg_word;
    end
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef I2S_FEEDER_STATS_EN
  logic stall_now;
  assign stall_now = (state_q == IDLE) && !fifo_empty && tx_full;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (state_q == ACCESS && !cur_cfg) begin
        stat_words <= stat_words + 16'd1;
      end
      if (stall_now && stat_stall != 16'hFFFF) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule
